// File: rtl/peak_decimator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : peak_decimator_pkg
// Description : Shared mode and state encodings for the peak decimator.
// Revision    : 1.0
// ============================================================================
package peak_decimator_pkg;

    localparam logic MODE_SAMPLE = 1'b0;
    localparam logic MODE_PEAK   = 1'b1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_e;

endpackage : peak_decimator_pkg
`default_nettype wire

// File: rtl/peak_decimator_if.sv
`default_nettype none
// ============================================================================
// Module      : peak_decimator_if
// Description : Sample input stream and result handshake of the decimator.
// Revision    : 1.0
// ============================================================================
interface peak_decimator_if #(
    parameter int INPUT_WIDTH = 16,
    parameter int RATIO_WIDTH = 8
);
    logic signed [INPUT_WIDTH-1:0] x;
    logic                          x_valid;
    logic        [RATIO_WIDTH-1:0] ratio;
    logic                          mode;
    logic signed [INPUT_WIDTH-1:0] y_min;
    logic signed [INPUT_WIDTH-1:0] y_max;
    logic                          y_valid;
    logic                          y_ready;
    logic                          overrun;

    modport master (
        output x, x_valid, ratio, mode, y_ready,
        input  y_min, y_max, y_valid, overrun
    );

    modport slave (
        input  x, x_valid, ratio, mode, y_ready,
        output y_min, y_max, y_valid, overrun
    );
endinterface : peak_decimator_if
`default_nettype wire

// File: rtl/peak_decimator_minmax_accum.sv
`default_nettype none
// ============================================================================
// Module      : minmax_accum
// Description : Window min/max/first registers; exposes next values so the
//               completing sample is included in the result.
// Revision    : 1.0
// ============================================================================
module minmax_accum #(
    parameter int INPUT_WIDTH = 16
) (
    input  wire logic                          clk,
    input  wire logic                          rst_n,
    input  wire logic                          load,
    input  wire logic                          update,
    input  wire logic signed [INPUT_WIDTH-1:0] x,
    output logic signed      [INPUT_WIDTH-1:0] min_next,
    output logic signed      [INPUT_WIDTH-1:0] max_next,
    output logic signed      [INPUT_WIDTH-1:0] first_next
);

    logic signed [INPUT_WIDTH-1:0] r_min;
    logic signed [INPUT_WIDTH-1:0] r_max;
    logic signed [INPUT_WIDTH-1:0] r_first;

    always_comb begin
        min_next   = r_min;
        max_next   = r_max;
        first_next = r_first;
        if (load) begin
            min_next   = x;
            max_next   = x;
            first_next = x;
        end else if (update) begin
            min_next = (x < r_min) ? x : r_min;
            max_next = (x > r_max) ? x : r_max;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_min   <= '0;
            r_max   <= '0;
            r_first <= '0;
        end else if (load || update) begin
            r_min   <= min_next;
            r_max   <= max_next;
            r_first <= first_next;
        end
    end

endmodule : minmax_accum
`default_nettype wire

// File: rtl/peak_decimator.sv
`default_nettype none
// ============================================================================
// Module      : peak_decimator
// Description : Window decimator (SAMPLE / PEAK) with one-deep output register.
// Revision    : 1.0
// ============================================================================
module peak_decimator
    import peak_decimator_pkg::*;
#(
    parameter int INPUT_WIDTH = 16,
    parameter int RATIO_WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    peak_decimator_if.slave       bus
);

    state_e                        r_state;
    logic        [RATIO_WIDTH-1:0] r_count;
    logic        [RATIO_WIDTH-1:0] r_ratio;
    logic                          r_mode;
    logic signed [INPUT_WIDTH-1:0] r_y_min;
    logic signed [INPUT_WIDTH-1:0] r_y_max;
    logic                          r_y_valid;
    logic                          r_overrun;

    logic        [RATIO_WIDTH-1:0] w_ratio_eff;
    logic        [RATIO_WIDTH-1:0] w_count_nxt;
    logic                          w_load;
    logic                          w_update;
    logic                          w_complete;
    logic                          w_mode_eff;
    logic signed [INPUT_WIDTH-1:0] w_min_nxt;
    logic signed [INPUT_WIDTH-1:0] w_max_nxt;
    logic signed [INPUT_WIDTH-1:0] w_first_nxt;

    assign w_ratio_eff = (bus.ratio == '0) ? RATIO_WIDTH'(1) : bus.ratio;
    assign w_count_nxt = r_count + 1'b1;
    assign w_load      = bus.x_valid && (r_state == ST_IDLE);
    assign w_update    = bus.x_valid && (r_state == ST_ACC);
    // A window opened this cycle takes its mode from the live input, not the latch.
    assign w_mode_eff  = (r_state == ST_IDLE) ? bus.mode : r_mode;
    assign w_complete  = (w_load   && (w_ratio_eff == RATIO_WIDTH'(1))) ||
                         (w_update && (w_count_nxt == r_ratio));

    minmax_accum #(
        .INPUT_WIDTH (INPUT_WIDTH)
    ) u_minmax_accum (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (w_load),
        .update     (w_update),
        .x          (bus.x),
        .min_next   (w_min_nxt),
        .max_next   (w_max_nxt),
        .first_next (w_first_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_ratio   <= '0;
            r_mode    <= MODE_SAMPLE;
            r_y_min   <= '0;
            r_y_max   <= '0;
            r_y_valid <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;

            if (w_load) begin
                r_ratio <= w_ratio_eff;
                r_mode  <= bus.mode;
                r_count <= RATIO_WIDTH'(1);
                r_state <= w_complete ? ST_IDLE : ST_ACC;
            end else if (w_update) begin
                r_count <= w_count_nxt;
                if (w_complete) begin
                    r_state <= ST_IDLE;
                end
            end

            if (w_complete) begin
                if (!r_y_valid || bus.y_ready) begin
                    r_y_min   <= (w_mode_eff == MODE_PEAK) ? w_min_nxt : w_first_nxt;
                    r_y_max   <= (w_mode_eff == MODE_PEAK) ? w_max_nxt : w_first_nxt;
                    r_y_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_y_valid && bus.y_ready) begin
                r_y_valid <= 1'b0;
            end
        end
    end

    assign bus.y_min   = r_y_min;
    assign bus.y_max   = r_y_max;
    assign bus.y_valid = r_y_valid;
    assign bus.overrun = r_overrun;

endmodule : peak_decimator
`default_nettype wire

// File: tb/tb_peak_decimator.sv
`default_nettype none
// ============================================================================
// Module      : tb_peak_decimator
// Description : Directed self-checking bench for peak_decimator.
// Revision    : 1.0
// ============================================================================
module tb_peak_decimator;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    peak_decimator_if #(.INPUT_WIDTH(16), .RATIO_WIDTH(8)) bus ();

    peak_decimator #(
        .INPUT_WIDTH (16),
        .RATIO_WIDTH (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic signed [15:0] v);
        bus.x       = v;
        bus.x_valid = 1'b1;
        tick();
        bus.x_valid = 1'b0;
    endtask

    task automatic idle();
        bus.x_valid = 1'b0;
        bus.y_ready = 1'b1;
        tick();
    endtask

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.x = 16'sd0; bus.x_valid = 1'b0; bus.ratio = 8'd0; bus.mode = 1'b0; bus.y_ready = 1'b0;
        tick(); tick();
        chk("reset y_min", int'(bus.y_min), 0);
        chk("reset y_max", int'(bus.y_max), 0);
        chk("reset y_valid", int'(bus.y_valid), 0);
        chk("reset overrun", int'(bus.overrun), 0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_peak_basic();
        idle();
        bus.mode = 1'b1; bus.ratio = 8'd4; bus.y_ready = 1'b1;
        feed(16'sd3); feed(-16'sd5); feed(16'sd7);
        chk("peak early valid", int'(bus.y_valid), 0);
        feed(16'sd1);
        chk("peak valid", int'(bus.y_valid), 1);
        chk("peak y_min", int'(bus.y_min), -5);
        chk("peak y_max", int'(bus.y_max), 7);
        tick();
        chk("peak valid one cycle", int'(bus.y_valid), 0);
    endtask

    task automatic test_sample_basic();
        int ovr = 0;
        idle();
        bus.mode = 1'b0; bus.ratio = 8'd3; bus.y_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            feed(16'(10 * i));
            if (bus.overrun) ovr++;
            if (i == 3) begin
                chk("sample1 valid", int'(bus.y_valid), 1);
                chk("sample1 y_min", int'(bus.y_min), 10);
                chk("sample1 y_max", int'(bus.y_max), 10);
            end
            if (i == 6) begin
                chk("sample2 valid", int'(bus.y_valid), 1);
                chk("sample2 y_min", int'(bus.y_min), 40);
                chk("sample2 y_max", int'(bus.y_max), 40);
            end
        end
        chk("sample overrun count", ovr, 0);
    endtask

    task automatic test_ratio0_gaps();
        idle();
        bus.mode = 1'b1; bus.ratio = 8'd0; bus.y_ready = 1'b1;
        feed(-16'sd2);
        chk("r0 first valid", int'(bus.y_valid), 1);
        chk("r0 first y_min", int'(bus.y_min), -2);
        chk("r0 first y_max", int'(bus.y_max), -2);
        tick();
        chk("r0 gap valid", int'(bus.y_valid), 0);
        feed(16'sd6);
        chk("r0 second valid", int'(bus.y_valid), 1);
        chk("r0 second y_min", int'(bus.y_min), 6);
        chk("r0 second y_max", int'(bus.y_max), 6);
    endtask

    task automatic test_backpressure();
        idle();
        bus.mode = 1'b1; bus.ratio = 8'd2; bus.y_ready = 1'b0;
        feed(16'sd1); feed(16'sd2);
        chk("bp valid", int'(bus.y_valid), 1);
        feed(16'sd3);
        chk("bp no early overrun", int'(bus.overrun), 0);
        feed(16'sd4);
        chk("bp overrun pulse", int'(bus.overrun), 1);
        chk("bp held y_min", int'(bus.y_min), 1);
        chk("bp held y_max", int'(bus.y_max), 2);
        tick();
        chk("bp overrun single", int'(bus.overrun), 0);
        chk("bp still valid", int'(bus.y_valid), 1);
        bus.y_ready = 1'b1;
        tick();
        chk("bp drained", int'(bus.y_valid), 0);
    endtask

    task automatic test_back_to_back();
        idle();
        bus.mode = 1'b0; bus.ratio = 8'd1; bus.y_ready = 1'b1;
        bus.x_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.x = 16'(100 - 50 * i);
            tick();
            chk("b2b valid", int'(bus.y_valid), 1);
            chk("b2b y_min", int'(bus.y_min), 100 - 50 * i);
        end
        bus.x_valid = 1'b0;
    endtask

    task automatic test_param_change();
        idle();
        bus.mode = 1'b1; bus.ratio = 8'd4; bus.y_ready = 1'b1;
        feed(16'sd9); feed(-16'sd9);
        bus.mode = 1'b0; bus.ratio = 8'd2;
        feed(16'sd0);
        chk("pc no early result", int'(bus.y_valid), 0);
        feed(16'sd0);
        chk("pc peak valid", int'(bus.y_valid), 1);
        chk("pc peak y_min", int'(bus.y_min), -9);
        chk("pc peak y_max", int'(bus.y_max), 9);
        feed(16'sd7); feed(16'sd8);
        chk("pc sample valid", int'(bus.y_valid), 1);
        chk("pc sample y_min", int'(bus.y_min), 7);
        chk("pc sample y_max", int'(bus.y_max), 7);
    endtask

    task automatic test_reset_mid();
        idle();
        bus.mode = 1'b1; bus.ratio = 8'd4; bus.y_ready = 1'b1;
        feed(16'sd100); feed(-16'sd100);
        rst_n = 1'b0;
        tick();
        chk("rm y_min", int'(bus.y_min), 0);
        chk("rm y_max", int'(bus.y_max), 0);
        chk("rm y_valid", int'(bus.y_valid), 0);
        rst_n = 1'b1;
        feed(16'sd5); feed(16'sd5); feed(16'sd5);
        chk("rm no residue", int'(bus.y_valid), 0);
        feed(-16'sd1);
        chk("rm valid", int'(bus.y_valid), 1);
        chk("rm y_min", int'(bus.y_min), -1);
        chk("rm y_max", int'(bus.y_max), 5);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_peak_basic();
        test_sample_basic();
        test_ratio0_gaps();
        test_backpressure();
        test_back_to_back();
        test_param_change();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_peak_decimator
`default_nettype wire
